// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding data-memory responder for a CPU memory stage. A request
//   is accepted only in IDLE. After a fixed LATENCY it produces a response that
//   holds until the CPU consumes it. Stores commit to storage on their
//   acceptance edge and echo the store data back. Loads return the stored word.
//   Addresses at or above DEPTH return resp_err=1. Such stores are dropped, and
//   such loads return 0.
//
// Parameters
//   ADDR_W   word-address width
//   DATA_W   data word width
//   DEPTH    implemented words (<= 2**ADDR_W)
//   LATENCY  acceptance-to-response cycles, 1..15
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_write    1 = store, 0 = load
//   req_addr     word address
//   req_wdata    store data
//   req_ready    request can be accepted this cycle (IDLE only)
//   resp_valid   response present
//   resp_rdata   load data, or store data echoed back
//   resp_err     request address was >= DEPTH
//   resp_ready   CPU consumes the response
//   stall        combinational pipeline-freeze request to the hazard unit
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic              stall
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;

  // NOTE: storage is deliberately not reset; contents must survive rst.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                req_in_range;
  logic [IDX_W-1:0]    wr_idx;

  // Source of the response fields: with LATENCY==1 the response is built on the
  // acceptance edge from the live request. Otherwise it is built from the
  // captured copy when BUSY expires.
  logic [ADDR_W-1:0]   src_addr;
  logic                src_write;
  logic [DATA_W-1:0]   src_wdata;
  logic                src_in_range;
  logic [IDX_W-1:0]    src_idx;
  logic [DATA_W-1:0]   resp_rdata_d;
  logic                resp_err_d;

  assign accept       = req_valid && (state_q == IDLE);
  assign req_in_range = {1'b0, req_addr} < DEPTH_W;
  assign wr_idx       = req_addr[IDX_W-1:0];

  assign src_addr     = (state_q == IDLE) ? req_addr  : addr_q;
  assign src_write    = (state_q == IDLE) ? req_write : write_q;
  assign src_wdata    = (state_q == IDLE) ? req_wdata : wdata_q;
  assign src_in_range = {1'b0, src_addr} < DEPTH_W;
  assign src_idx      = src_addr[IDX_W-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    resp_rdata_d = '0;
    resp_err_d   = !src_in_range;
    if (src_write) begin
      resp_rdata_d = src_wdata;
    end else if (src_in_range) begin
      resp_rdata_d = mem_q[src_idx];
    end
  end

  // Store commit. rst blocks the write so a request seen during reset never lands.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_write && req_in_range) begin
      mem_q[wr_idx] <= req_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_rdata_d;
              resp_err_q   <= resp_err_d;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = (req_valid && (state_q == IDLE)) ||
                      (state_q == BUSY) ||
                      ((state_q == RESP) && !resp_ready);

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. It uses two instances that share clk and
//   rst:
//     u_a : DEPTH=200, LATENCY=2 (store/load, back-pressure, range, reset)
//     u_b : DEPTH=256, LATENCY=1 (back-to-back single-cycle responses)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk;
  logic rst;

  logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err;
  logic        a_resp_ready, a_stall;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_resp_rdata;

  logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err;
  logic        b_resp_ready, b_stall;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .LATENCY(2)) u_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_req_valid),
    .req_write  (a_req_write),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .req_ready  (a_req_ready),
    .resp_valid (a_resp_valid),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err),
    .resp_ready (a_resp_ready),
    .stall      (a_stall)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1)) u_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_req_valid),
    .req_write  (b_req_write),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .req_ready  (b_req_ready),
    .resp_valid (b_resp_valid),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err),
    .resp_ready (b_resp_ready),
    .stall      (b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request to u_a once it is ready, then run until the first
  // resp_valid. lat is the number of edges from acceptance to resp_valid.
  // After acceptance the request inputs carry junk that must be ignored.
  task automatic a_run(input logic w, input logic [7:0] addr, input logic [31:0] data,
                       output int lat);
    int guard = 0;
    while (!a_req_ready && guard < 20) begin step(); guard++; end
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = data;
    step();
    a_req_valid = 1'b0; a_req_write = 1'b1; a_req_addr = 8'h05; a_req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin step(); lat++; end
    if (!a_resp_valid) begin
      $display("FAIL a_run timeout: resp_valid=%0b, required 1 within 20 cycles", a_resp_valid);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic b_run(input logic w, input logic [7:0] addr, input logic [31:0] data,
                       output int lat);
    int guard = 0;
    while (!b_req_ready && guard < 20) begin step(); guard++; end
    b_req_valid = 1'b1; b_req_write = w; b_req_addr = addr; b_req_wdata = data;
    step();
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 32'h0;
    lat = 1;
    while (!b_resp_valid && lat < 20) begin step(); lat++; end
    if (!b_resp_valid) begin
      $display("FAIL b_run timeout: resp_valid=%0b, required 1 within 20 cycles", b_resp_valid);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_wdata = 32'h0;
    a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 32'h0;
    b_resp_ready = 1'b1;
    step(); step();
    n_tests++; if (a_req_ready !== 1'b1) begin $display("FAIL reset req_ready: got %0b want 1", a_req_ready); n_fail++; end
    n_tests++; if (a_resp_valid !== 1'b0) begin $display("FAIL reset resp_valid: got %0b want 0", a_resp_valid); n_fail++; end
    n_tests++; if (a_resp_rdata !== 32'h0) begin $display("FAIL reset resp_rdata: got %h want 0", a_resp_rdata); n_fail++; end
    n_tests++; if (a_resp_err !== 1'b0) begin $display("FAIL reset resp_err: got %0b want 0", a_resp_err); n_fail++; end
    n_tests++; if (a_stall !== 1'b1) begin $display("FAIL reset stall with req_valid: got %0b want 1", a_stall); n_fail++; end
    a_req_valid = 1'b0;
    #1;
    n_tests++; if (a_stall !== 1'b0) begin $display("FAIL reset stall idle: got %0b want 0", a_stall); n_fail++; end
    rst = 1'b0;
    step();
    n_tests++; if (a_req_ready !== 1'b1) begin $display("FAIL post-reset req_ready: got %0b want 1", a_req_ready); n_fail++; end
  endtask

  task automatic test_store_load();
    int lat;
    a_resp_ready = 1'b1;
    a_run(1'b1, 8'h05, 32'hDEAD_BEEF, lat);
    n_tests++; if (lat !== 2) begin $display("FAIL store latency: got %0d want 2", lat); n_fail++; end
    n_tests++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL store echo: got %h want deadbeef", a_resp_rdata); n_fail++; end
    n_tests++; if (a_resp_err !== 1'b0) begin $display("FAIL store err: got %0b want 0", a_resp_err); n_fail++; end
    step();
    n_tests++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      $display("FAIL store consume: valid=%0b ready=%0b want 0/1", a_resp_valid, a_req_ready); n_fail++; end
    n_tests++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL idle hold rdata: got %h want deadbeef", a_resp_rdata); n_fail++; end
    a_run(1'b0, 8'h05, 32'h0, lat);
    n_tests++; if (lat !== 2) begin $display("FAIL load latency: got %0d want 2", lat); n_fail++; end
    n_tests++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL load data: got %h want deadbeef", a_resp_rdata); n_fail++; end
    n_tests++; if (a_resp_err !== 1'b0) begin $display("FAIL load err: got %0b want 0", a_resp_err); n_fail++; end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    a_resp_ready = 1'b0;
    a_run(1'b0, 8'h05, 32'h0, lat);
    // A store offered during RESP must not be accepted.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h05; a_req_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEAD_BEEF || a_stall !== 1'b1 || a_req_ready !== 1'b0) begin
        $display("FAIL backpressure cycle %0d: valid=%0b rdata=%h stall=%0b ready=%0b want 1/deadbeef/1/0",
                 i, a_resp_valid, a_resp_rdata, a_stall, a_req_ready);
        n_fail++;
      end
      step();
    end
    a_req_valid = 1'b0; a_resp_ready = 1'b1;
    #1;
    n_tests++; if (a_stall !== 1'b0) begin $display("FAIL backpressure release stall: got %0b want 0", a_stall); n_fail++; end
    step();
    n_tests++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      $display("FAIL backpressure to idle: valid=%0b ready=%0b want 0/1", a_resp_valid, a_req_ready); n_fail++; end
    a_run(1'b0, 8'h05, 32'h0, lat);
    n_tests++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL store during resp leaked: got %h want deadbeef", a_resp_rdata); n_fail++; end
    step();
  endtask

  task automatic test_out_of_range();
    int lat;
    a_resp_ready = 1'b1;
    a_run(1'b1, 8'hC8, 32'h0000_1234, lat);
    n_tests++; if (a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0000_1234) begin
      $display("FAIL oor store: err=%0b rdata=%h want 1/00001234", a_resp_err, a_resp_rdata); n_fail++; end
    a_run(1'b0, 8'hC8, 32'h0, lat);
    n_tests++; if (a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0) begin
      $display("FAIL oor load: err=%0b rdata=%h want 1/0", a_resp_err, a_resp_rdata); n_fail++; end
    a_run(1'b1, 8'hC7, 32'hC7C7_0000, lat);
    a_run(1'b0, 8'hC7, 32'h0, lat);
    n_tests++; if (a_resp_err !== 1'b0 || a_resp_rdata !== 32'hC7C7_0000) begin
      $display("FAIL last word: err=%0b rdata=%h want 0/c7c70000", a_resp_err, a_resp_rdata); n_fail++; end
    a_run(1'b0, 8'hFF, 32'h0, lat);
    n_tests++; if (a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0) begin
      $display("FAIL top addr: err=%0b rdata=%h want 1/0", a_resp_err, a_resp_rdata); n_fail++; end
    a_run(1'b0, 8'h05, 32'h0, lat);
    n_tests++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL storage after oor: got %h want deadbeef", a_resp_rdata); n_fail++; end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    b_resp_ready = 1'b1;
    b_run(1'b1, 8'h00, 32'h0000_00A0, lat);
    n_tests++; if (lat !== 1) begin $display("FAIL lat1 store latency: got %0d want 1", lat); n_fail++; end
    b_run(1'b1, 8'h01, 32'h0000_00A1, lat);
    step();
    // Hold req_valid high across two loads.
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h00;
    step();
    n_tests++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'hA0 || b_req_ready !== 1'b0) begin
      $display("FAIL b2b first: valid=%0b rdata=%h ready=%0b want 1/a0/0", b_resp_valid, b_resp_rdata, b_req_ready); n_fail++; end
    n_tests++; if (b_stall !== 1'b0) begin $display("FAIL b2b resp stall: got %0b want 0", b_stall); n_fail++; end
    b_req_addr = 8'h01;
    step();
    n_tests++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1 || b_stall !== 1'b1) begin
      $display("FAIL b2b gap: valid=%0b ready=%0b stall=%0b want 0/1/1", b_resp_valid, b_req_ready, b_stall); n_fail++; end
    step();
    n_tests++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'hA1 || b_resp_err !== 1'b0) begin
      $display("FAIL b2b second: valid=%0b rdata=%h err=%0b want 1/a1/0", b_resp_valid, b_resp_rdata, b_resp_err); n_fail++; end
    b_req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int guard = 0;
    a_resp_ready = 1'b1;
    while (!a_req_ready && guard < 20) begin step(); guard++; end
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h10; a_req_wdata = 32'hA5A5_A5A5;
    step();
    a_req_valid = 1'b0;
    n_tests++; if (a_resp_valid !== 1'b0 || a_stall !== 1'b1) begin
      $display("FAIL mid-op busy: valid=%0b stall=%0b want 0/1", a_resp_valid, a_stall); n_fail++; end
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h10; a_req_wdata = 32'h3333_3333;
    step();
    n_tests++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      $display("FAIL mid-op in reset: valid=%0b ready=%0b want 0/1", a_resp_valid, a_req_ready); n_fail++; end
    step();
    rst = 1'b0; a_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
        $display("FAIL mid-op after reset %0d: valid=%0b ready=%0b want 0/1", i, a_resp_valid, a_req_ready); n_fail++; end
    end
    a_run(1'b0, 8'h10, 32'h0, lat);
    n_tests++; if (a_resp_rdata !== 32'hA5A5_A5A5) begin $display("FAIL committed store kept: got %h want a5a5a5a5", a_resp_rdata); n_fail++; end
    step();
    // Reset while holding a response discards it and clears the outputs.
    a_resp_ready = 1'b0;
    a_run(1'b0, 8'h10, 32'h0, lat);
    rst = 1'b1;
    step();
    n_tests++; if (a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin
      $display("FAIL reset in resp: valid=%0b rdata=%h err=%0b want 0/0/0", a_resp_valid, a_resp_rdata, a_resp_err); n_fail++; end
    rst = 1'b0; a_resp_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
